hilo_commit_unit: RTL and testbench
===================================

// Module: hilo_commit_unit
// PURPOSE
//  HI/LO architectural register unit directly downstream of the EX-stage ALU. Captures
//  the ALU's 64-bit result for MTHI/MTLO/MULT/MULTU/DIV/DIVU and holds it in a
//  one-entry MEM-stage pending slot. Commits to architectural HI/LO only when that
//  instruction leaves MEM unflushed.
//  Forwards the pending value on hilo_fwd, which drives the ALU hilo operand, so MFHI/MFLO
//  right behind a writer sees the new value.
// PARAMETERS
//  DW        32   width of HI and of LO; the ALU result is 2*DW
// PORTS
//  clk          in   1     clock, all state on rising edge
//  rst          in   1     asynchronous active-low reset
//  ex_valid     in   1     EX-stage instruction valid
//  ex_hilo_op   in   2     0 NONE, 1 MTHI, 2 MTLO, 3 WR64 (mult/div)
//  ex_wdata     in   64    ALU result y; MTHI/MTLO use [31:0], WR64 uses {HI,LO}=[63:32],[31:0]
//  ex_stall     in   1     EX held (ALU div_stall or other); request not captured
//  ex_flush     in   1     kill the EX instruction this cycle
//  mem_stall    in   1     MEM stage held
//  mem_flush    in   1     exception at MEM: kill pending slot and the EX request
//  hilo_fwd     out  64    {HI,LO} as seen by EX: architectural merged with pending slot
//  hi_arch      out  32    committed HI
//  lo_arch      out  32    committed LO
//  pend_valid   out  1     pending slot occupied
// BEHAVIOUR
//  - Reset (rst=0, async): hi_arch=lo_arch=0, pending slot invalid; pend_valid=0 and hilo_fwd=0.
//    Any in-flight mult/div/MT write is discarded.
//  - ex_adv = ex_valid & (ex_hilo_op!=NONE) & ~ex_stall & ~ex_flush & ~mem_stall & ~mem_flush.
//  - Per rising edge, in priority order:
//    1. mem_flush=1: slot <= invalid. No commit, no capture.
//    2. mem_stall=1: slot holds. No commit, no capture.
//    3. else: commit the slot if valid, then slot <= {ex_adv, op, wdata}.
//       Commit writes: MTHI -> hi_arch=wdata[31:0]; MTLO -> lo_arch=wdata[31:0];
//       WR64 -> hi_arch=wdata[63:32], lo_arch=wdata[31:0].
//  - Commit and capture can happen in the same cycle (back-to-back writers).
//    Slot depth 1 is sufficient; capture never stalls the pipeline.
//  - Latency:
//    - ex_wdata is visible on hilo_fwd one cycle after capture (combinational from the slot).
//    - hi_arch/lo_arch update one cycle after that, or later under mem_stall.
//  - hilo_fwd is combinational. With the slot valid, the slot's op overrides the matching half:
//    MTHI -> HI only, MTLO -> LO only, WR64 -> both. With the slot invalid, hilo_fwd = {hi_arch,lo_arch}.
//  - ex_stall high (divide in progress): no capture. Capture happens in the first cycle
//    ex_stall is low, using that cycle's ex_wdata.
//  - ex_flush alone does not affect the slot. mem_flush kills the slot and the younger EX request.
//  - ex_hilo_op is ignored when ex_valid=0. Width arithmetic is plain bit slicing, with no sign handling.
// STRUCTURE
//  - Shared defines header (alongside the ALU control defines): HILO_OP_NONE/MTHI/MTLO/WR64 encodings.
//  - One sub-module, hilo_pending_slot: valid/op/data register with hold/flush/load controls
//    and the merge mux that produces hilo_fwd.
//  - The top level holds the architectural registers and the advance/commit logic.
// TESTING
//  1. Reset mid-op: slot holding WR64, pull rst low -> hi_arch=lo_arch=0, pend_valid=0,
//     hilo_fwd=0 immediately.
//  2. WR64 ex_wdata=64'h0000_0001_FFFF_FFFE, no stalls
//     -> hilo_fwd=that value next cycle; the cycle after, hi_arch=32'h1, lo_arch=32'hFFFF_FFFE.
//  3. MTHI 32'hDEAD_BEEF followed directly by MTLO 32'h1234_5678
//     -> hilo_fwd reads {DEADBEEF, old LO}, then {DEADBEEF,12345678}; arch ends at {DEADBEEF,12345678}.
//  4. WR64 presented with ex_stall=1 for 32 cycles then 0 -> no capture while stalled;
//     captures the final ex_wdata on the first unstalled edge.
//  5. Slot holds MTLO 32'hAAAA_AAAA, mem_flush=1 together with a new WR64 at EX
//     -> slot cleared, lo_arch unchanged, WR64 dropped.
//  6. mem_stall=1 for 3 cycles with the slot valid and a WR64 at EX
//     -> arch unchanged and slot unchanged. After release: commit, then WR64 captured on that same edge.

Source files
------------

// File: rtl/hilo_commit_unit_pkg.sv
// -----------------------------------------------------------------------------
// hilo_commit_unit_pkg
//   Shared definitions for the HI/LO commit unit: the HI/LO write-op encoding
//   (matching the ALU control defines) and the default register width.
// -----------------------------------------------------------------------------
package hilo_commit_unit_pkg;

    // Width of HI and of LO; the ALU result feeding the unit is twice this.
    localparam int HILO_DW = 32;

    // HI/LO write operation carried alongside the EX-stage instruction.
    typedef enum logic [1:0] {
        HILO_OP_NONE = 2'd0,  // no HI/LO write
        HILO_OP_MTHI = 2'd1,  // HI <= wdata[DW-1:0]
        HILO_OP_MTLO = 2'd2,  // LO <= wdata[DW-1:0]
        HILO_OP_WR64 = 2'd3   // {HI,LO} <= wdata (mult/div)
    } hilo_op_e;

endpackage : hilo_commit_unit_pkg

// File: rtl/hilo_pending_slot.sv
// -----------------------------------------------------------------------------
// hilo_pending_slot
//   One-entry MEM-stage holding register for an in-flight HI/LO write, plus the
//   merge mux that overlays the pending write onto the architectural value so
//   the EX stage always sees the youngest HI/LO.
//
// Ports
//   clk        in   clock
//   rst        in   asynchronous active-low reset
//   flush      in   invalidate the slot (highest priority)
//   hold       in   keep the slot contents unchanged
//   load_valid in   valid bit loaded when neither flush nor hold
//   load_op    in   op loaded alongside load_valid
//   load_data  in   2*DW data loaded alongside load_valid
//   arch_hi    in   committed HI
//   arch_lo    in   committed LO
//   slot_valid out  slot occupied
//   slot_op    out  op held in the slot
//   slot_data  out  data held in the slot
//   fwd        out  {HI,LO} with the pending write overlaid
// -----------------------------------------------------------------------------
module hilo_pending_slot
    import hilo_commit_unit_pkg::*;
#(
    parameter int DW = HILO_DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            hold,
    input  logic            load_valid,
    input  hilo_op_e        load_op,
    input  logic [2*DW-1:0] load_data,
    input  logic [DW-1:0]   arch_hi,
    input  logic [DW-1:0]   arch_lo,
    output logic            slot_valid,
    output hilo_op_e        slot_op,
    output logic [2*DW-1:0] slot_data,
    output logic [2*DW-1:0] fwd
);

    // NOTE: sequential state is written with <= only, so every register in this
    // block samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_valid <= 1'b0;
            slot_op    <= HILO_OP_NONE;
            // NOTE: the payload does not strictly need a reset (it is qualified by
            // slot_valid), but it is tiny and a known value keeps fwd clean.
            slot_data  <= '0;
        end else if (flush) begin
            slot_valid <= 1'b0;
        end else if (!hold) begin
            slot_valid <= load_valid;
            slot_op    <= load_op;
            slot_data  <= load_data;
        end
    end

    // Overlay: MTHI/MTLO carry their value in the low half of the data word.
    logic [DW-1:0] fwd_hi;
    logic [DW-1:0] fwd_lo;

    always_comb begin
        // NOTE: defaults first so every path assigns both halves; no latch.
        fwd_hi = arch_hi;
        fwd_lo = arch_lo;
        if (slot_valid) begin
            case (slot_op)
                HILO_OP_MTHI: fwd_hi = slot_data[DW-1:0];
                HILO_OP_MTLO: fwd_lo = slot_data[DW-1:0];
                HILO_OP_WR64: begin
                    fwd_hi = slot_data[2*DW-1:DW];
                    fwd_lo = slot_data[DW-1:0];
                end
                default: ;
            endcase
        end
    end

    assign fwd = {fwd_hi, fwd_lo};

endmodule : hilo_pending_slot

// File: rtl/hilo_commit_unit.sv
// -----------------------------------------------------------------------------
// hilo_commit_unit
//   HI/LO architectural register unit behind the EX-stage ALU. A HI/LO writer
//   leaving EX is parked in a one-entry MEM slot and commits to HI/LO only when
//   it leaves MEM unflushed. The slot is forwarded to EX so MFHI/MFLO directly
//   behind a writer reads the new value.
//
// Ports
//   clk        in   clock
//   rst        in   asynchronous active-low reset
//   ex_valid   in   EX instruction valid
//   ex_hilo_op in   HI/LO op of the EX instruction (hilo_op_e encoding)
//   ex_wdata   in   ALU result, 2*DW
//   ex_stall   in   EX held; no capture
//   ex_flush   in   kill the EX instruction
//   mem_stall  in   MEM held; slot and arch registers hold
//   mem_flush  in   kill the slot and the EX request
//   hilo_fwd   out  {HI,LO} as seen by EX
//   hi_arch    out  committed HI
//   lo_arch    out  committed LO
//   pend_valid out  slot occupied
// -----------------------------------------------------------------------------
module hilo_commit_unit
    import hilo_commit_unit_pkg::*;
#(
    parameter int DW = HILO_DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [1:0]      ex_hilo_op,
    input  logic [2*DW-1:0] ex_wdata,
    input  logic            ex_stall,
    input  logic            ex_flush,
    input  logic            mem_stall,
    input  logic            mem_flush,
    output logic [2*DW-1:0] hilo_fwd,
    output logic [DW-1:0]   hi_arch,
    output logic [DW-1:0]   lo_arch,
    output logic            pend_valid
);

    hilo_op_e        ex_op;
    logic            ex_adv;
    logic            commit;
    hilo_op_e        slot_op;
    logic [2*DW-1:0] slot_data;

    assign ex_op = hilo_op_e'(ex_hilo_op);

    // An EX writer moves into MEM only when both stages advance cleanly.
    assign ex_adv = ex_valid && (ex_op != HILO_OP_NONE) && !ex_stall && !ex_flush
                    && !mem_stall && !mem_flush;

    // The slot's instruction leaves MEM this edge and was not killed.
    assign commit = pend_valid && !mem_stall && !mem_flush;

    hilo_pending_slot #(.DW(DW)) u_slot (
        .clk        (clk),
        .rst        (rst),
        .flush      (mem_flush),
        .hold       (mem_stall),
        .load_valid (ex_adv),
        .load_op    (ex_op),
        .load_data  (ex_wdata),
        .arch_hi    (hi_arch),
        .arch_lo    (lo_arch),
        .slot_valid (pend_valid),
        .slot_op    (slot_op),
        .slot_data  (slot_data),
        .fwd        (hilo_fwd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_arch <= '0;
            lo_arch <= '0;
        end else if (commit) begin
            case (slot_op)
                HILO_OP_MTHI: hi_arch <= slot_data[DW-1:0];
                HILO_OP_MTLO: lo_arch <= slot_data[DW-1:0];
                HILO_OP_WR64: begin
                    hi_arch <= slot_data[2*DW-1:DW];
                    lo_arch <= slot_data[DW-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule : hilo_commit_unit

// File: tb/tb_hilo_commit_unit.sv
// -----------------------------------------------------------------------------
// tb_hilo_commit_unit
//   Self-checking bench for hilo_commit_unit. The reference model keeps the
//   committed {HI,LO} and a queue of at most one pending write; the forwarded
//   value is simply "architectural state with the pending write applied".
// -----------------------------------------------------------------------------
module tb_hilo_commit_unit;
    import hilo_commit_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [1:0]  ex_hilo_op;
    logic [63:0] ex_wdata;
    logic        ex_stall;
    logic        ex_flush;
    logic        mem_stall;
    logic        mem_flush;
    logic [63:0] hilo_fwd;
    logic [31:0] hi_arch;
    logic [31:0] lo_arch;
    logic        pend_valid;

    hilo_commit_unit #(.DW(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_hilo_op (ex_hilo_op),
        .ex_wdata   (ex_wdata),
        .ex_stall   (ex_stall),
        .ex_flush   (ex_flush),
        .mem_stall  (mem_stall),
        .mem_flush  (mem_flush),
        .hilo_fwd   (hilo_fwd),
        .hi_arch    (hi_arch),
        .lo_arch    (lo_arch),
        .pend_valid (pend_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    typedef struct {
        logic [1:0]  op;
        logic [63:0] data;
    } pend_t;

    logic [31:0] m_hi;
    logic [31:0] m_lo;
    pend_t       m_pend[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Result of performing one HI/LO write on a {HI,LO} pair.
    function automatic logic [63:0] apply_write(logic [63:0] hl, pend_t p);
        logic [63:0] r;
        r = hl;
        case (p.op)
            2'd1: r[63:32] = p.data[31:0];
            2'd2: r[31:0]  = p.data[31:0];
            2'd3: r        = p.data;
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic [63:0] model_fwd();
        if (m_pend.size() != 0) return apply_write({m_hi, m_lo}, m_pend[0]);
        return {m_hi, m_lo};
    endfunction

    // Advance the model by one clock edge using the inputs present at the edge.
    task automatic model_edge();
        logic [63:0] hl;
        pend_t       p;
        if (mem_flush) begin
            m_pend.delete();
        end else if (!mem_stall) begin
            if (m_pend.size() != 0) begin
                hl = apply_write({m_hi, m_lo}, m_pend[0]);
                m_hi = hl[63:32];
                m_lo = hl[31:0];
                m_pend.delete();
            end
            if (ex_valid && ex_hilo_op != 2'd0 && !ex_stall && !ex_flush) begin
                p.op   = ex_hilo_op;
                p.data = ex_wdata;
                m_pend.push_back(p);
            end
        end
    endtask

    task automatic model_reset();
        m_hi = '0;
        m_lo = '0;
        m_pend.delete();
    endtask

    // ------------------------------------------------------------- checking
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".fwd"},  hilo_fwd, model_fwd());
        check({tag, ".hi"},   64'(hi_arch), 64'(m_hi));
        check({tag, ".lo"},   64'(lo_arch), 64'(m_lo));
        check({tag, ".pend"}, 64'(pend_valid), 64'(m_pend.size() != 0));
    endtask

    // One clock: edge, model update, then sample 1 time unit after the edge.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        ex_valid   = 1'b0;
        ex_hilo_op = 2'd0;
        ex_wdata   = '0;
        ex_stall   = 1'b0;
        ex_flush   = 1'b0;
        mem_stall  = 1'b0;
        mem_flush  = 1'b0;
    endtask

    task automatic ex_write(input logic [1:0] op, input logic [63:0] d);
        ex_valid   = 1'b1;
        ex_hilo_op = op;
        ex_wdata   = d;
    endtask

    // --------------------------------------------------------------- stimulus
    logic [63:0] last_d;
    logic [31:0] saved_lo;
    logic [31:0] saved_hi;

    initial begin
        idle_inputs();
        model_reset();
        rst = 1'b0;
        #12;
        check_all("reset_state");
        check("reset_fwd_zero", hilo_fwd, 64'h0);
        @(negedge clk);
        rst = 1'b1;

        // Test 1: async reset with a WR64 parked in the slot.
        ex_write(HILO_OP_WR64, 64'hCAFE_F00D_1234_5678);
        tick("t1_capture");
        idle_inputs();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("t1_rst_fwd",  hilo_fwd, 64'h0);
        check("t1_rst_hi",   64'(hi_arch), 64'h0);
        check("t1_rst_lo",   64'(lo_arch), 64'h0);
        check("t1_rst_pend", 64'(pend_valid), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        tick("t1_after");

        // Test 2: WR64, no stalls.
        ex_write(HILO_OP_WR64, 64'h0000_0001_FFFF_FFFE);
        tick("t2_cap");
        check("t2_fwd", hilo_fwd, 64'h0000_0001_FFFF_FFFE);
        idle_inputs();
        tick("t2_commit");
        check("t2_hi", 64'(hi_arch), 64'h1);
        check("t2_lo", 64'(lo_arch), 64'hFFFF_FFFE);

        // Test 3: MTHI then MTLO back to back (upper bits are junk, must be ignored).
        ex_write(HILO_OP_MTHI, 64'h5555_5555_DEAD_BEEF);
        tick("t3_mthi");
        check("t3_fwd1", hilo_fwd, 64'hDEAD_BEEF_FFFF_FFFE);
        ex_write(HILO_OP_MTLO, 64'h9999_9999_1234_5678);
        tick("t3_mtlo");
        check("t3_fwd2", hilo_fwd, 64'hDEAD_BEEF_1234_5678);
        check("t3_hi_mid", 64'(hi_arch), 64'hDEAD_BEEF);
        idle_inputs();
        tick("t3_end");
        check("t3_arch", {hi_arch, lo_arch}, 64'hDEAD_BEEF_1234_5678);

        // Test 4: WR64 held by ex_stall for 32 cycles, data changing meanwhile.
        ex_write(HILO_OP_WR64, 64'h0);
        ex_stall = 1'b1;
        for (int i = 0; i < 32; i++) begin
            ex_wdata = {$urandom, $urandom};
            tick("t4_stalled");
        end
        ex_stall = 1'b0;
        last_d   = {$urandom, $urandom};
        ex_wdata = last_d;
        tick("t4_release");
        check("t4_fwd", hilo_fwd, last_d);
        idle_inputs();
        tick("t4_commit");
        check("t4_arch", {hi_arch, lo_arch}, last_d);

        // Test 5: MTLO in slot, mem_flush with a WR64 at EX.
        saved_lo = lo_arch;
        ex_write(HILO_OP_MTLO, 64'h0000_0000_AAAA_AAAA);
        tick("t5_cap");
        ex_write(HILO_OP_WR64, 64'h7777_7777_8888_8888);
        mem_flush = 1'b1;
        tick("t5_flush");
        check("t5_pend", 64'(pend_valid), 64'h0);
        check("t5_lo", 64'(lo_arch), 64'(saved_lo));
        idle_inputs();
        tick("t5_after");
        check("t5_fwd", hilo_fwd, {hi_arch, saved_lo});

        // Test 6: mem_stall for 3 cycles with slot valid and a WR64 at EX.
        saved_hi = hi_arch;
        ex_write(HILO_OP_MTHI, 64'h0000_0000_0BAD_CAFE);
        tick("t6_cap");
        ex_write(HILO_OP_WR64, 64'h1111_2222_3333_4444);
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick("t6_stall");
            check("t6_hi_hold", 64'(hi_arch), 64'(saved_hi));
        end
        mem_stall = 1'b0;
        tick("t6_release");
        check("t6_hi", 64'(hi_arch), 64'h0BAD_CAFE);
        check("t6_fwd", hilo_fwd, 64'h1111_2222_3333_4444);
        idle_inputs();
        tick("t6_end");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            ex_valid   = ($urandom_range(0, 3) != 0);
            ex_hilo_op = 2'($urandom_range(0, 3));
            ex_wdata   = {$urandom, $urandom};
            ex_stall   = ($urandom_range(0, 3) == 0);
            ex_flush   = ($urandom_range(0, 7) == 0);
            mem_stall  = ($urandom_range(0, 4) == 0);
            mem_flush  = ($urandom_range(0, 9) == 0);
            tick("rand");
        end
        idle_inputs();
        tick("drain1");
        tick("drain2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_hilo_commit_unit
